// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the bouncing-ball/paddle game.
// Holds the sequencer state encoding, the 640x480 playfield limits, the
// coordinate and score widths, and a small saturating-increment helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int X_MIN   = 30;
  localparam int X_MAX   = 610;
  localparam int Y_MIN   = 30;
  localparam int Y_MAX   = 450;

  localparam int COORD_W = 11;
  localparam int SCORE_W = 8;

  // Score counts up to all-ones and then sticks there.
  function automatic logic [SCORE_W-1:0] satIncScore(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_ctrl_step_sched.sv
// step_sched: per-frame ball step scheduler.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load_i    - frame_tick seen in PLAY (no miss): start a new burst
//   clear_i   - drop any pending steps (miss)
//   speed_i   - pixels per frame minus 1
//   step_o    - registered one-pixel strobe, speed_i+1 cycles per burst
module step_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       clear_i,
  input  logic [1:0] speed_i,
  output logic       step_o
);

  logic [1:0] cnt_q;
  logic       step_q;

  // The first strobe of a burst is issued straight from the load, so the
  // counter only holds the steps that remain after it. A new load always
  // wins, which drops whatever was left of the previous burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      step_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= speed_i;
      step_q <= 1'b1;
    end else if (clear_i) begin
      cnt_q  <= 2'd0;
      step_q <= 1'b0;
    end else if (cnt_q != 2'd0) begin
      cnt_q  <= cnt_q - 2'd1;
      step_q <= 1'b1;
    end else begin
      step_q <= 1'b0;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the bouncing-ball/paddle VGA game.
// Runs the IDLE/SERVE/PLAY/MISS/OVER state machine, keeps score, lives and
// ball speed, and drives the ball datapath with step/serve/bounce strobes.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   frame_tick        - one-cycle pulse per frame (start of vblank)
//   start_btn         - debounced, synchronised start button level
//   ball_x, ball_y    - current ball position
//   paddle_y          - top edge of the left paddle
//   ball_step         - strobe: ball advances one pixel
//   ball_serve        - strobe: ball reloads its serve position
//   bounce_x          - strobe: force ball x direction positive
//   score, lives      - hit count (saturating) and remaining lives
//   speed             - pixels per frame minus 1
//   state, game_over  - FSM encoding and OVER indicator
// All outputs are registered.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int HIT_X        = 40,
  parameter int MISS_X       = 30,
  parameter int PADDLE_H     = 64,
  parameter int SPEEDUP_HITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] paddle_y,
  output logic        ball_step,
  output logic        ball_serve,
  output logic        bounce_x,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [1:0]  speed,
  output logic [2:0]  state,
  output logic        game_over
);

  import game_pkg::*;

  localparam logic [10:0] HIT_XV  = 11'(HIT_X);
  localparam logic [10:0] MISS_XV = 11'(MISS_X);

  state_t      state_q;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q;
  logic [1:0]  speed_q, speed_d;
  logic [3:0]  hitCnt_q, hitCnt_d;
  logic [7:0]  frameCnt_q;
  logic        lockout_q, btn_q, armed_q;
  logic        serve_q, bounce_q, over_q;

  logic        startEdge, playTick, inWindow, hit, miss;
  logic [11:0] yBall, yTop, yBot;

  // armed_q stays low for the first cycle out of reset, so the button copy
  // catches up with a button held through reset before any edge can count.
  assign startEdge = start_btn & ~btn_q & armed_q;
  assign playTick  = frame_tick & (state_q == ST_PLAY);

  // Window bounds are formed at 12 bits so a paddle near the bottom of the
  // coordinate range cannot wrap its lower edge back to the top.
  assign yBall    = {1'b0, ball_y};
  assign yTop     = {1'b0, paddle_y};
  assign yBot     = yTop + 12'(PADDLE_H);
  assign inWindow = (yBall >= yTop) && (yBall < yBot);

  assign hit  = playTick & (ball_x <= HIT_XV) & inWindow & ~lockout_q;
  assign miss = playTick & (ball_x <= MISS_XV) & ~hit & ~lockout_q;

  step_sched u_stepSched (
    .clk     (clk),
    .rst     (rst),
    .load_i  (playTick & ~miss),
    .clear_i (miss),
    .speed_i (speed_q),
    .step_o  (ball_step)
  );

  // Candidate values after a hit: score saturates, every SPEEDUP_HITS-th
  // hit wraps the hit counter and bumps speed (which saturates at 3).
  always_comb begin
    score_d  = satIncScore(score_q);
    hitCnt_d = hitCnt_q + 4'd1;
    speed_d  = speed_q;
    if (hitCnt_d == 4'(SPEEDUP_HITS)) begin
      hitCnt_d = 4'd0;
      speed_d  = (speed_q == 2'd3) ? speed_q : speed_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      score_q    <= 8'd0;
      lives_q    <= 2'(LIVES);
      speed_q    <= 2'd0;
      hitCnt_q   <= 4'd0;
      frameCnt_q <= 8'd0;
      lockout_q  <= 1'b0;
      btn_q      <= 1'b0;
      armed_q    <= 1'b0;
      serve_q    <= 1'b0;
      bounce_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      btn_q    <= start_btn;
      armed_q  <= 1'b1;
      serve_q  <= 1'b0;
      bounce_q <= 1'b0;
      // A hit needs ball_x <= HIT_X, so this never fights the set below.
      if (frame_tick && (ball_x > HIT_XV)) lockout_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (startEdge) begin
            score_q    <= 8'd0;
            lives_q    <= 2'(LIVES);
            speed_q    <= 2'd0;
            hitCnt_q   <= 4'd0;
            serve_q    <= 1'b1;
            frameCnt_q <= 8'(SERVE_FRAMES);
            over_q     <= 1'b0;
            state_q    <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            frameCnt_q <= frameCnt_q - 8'd1;
            if (frameCnt_q == 8'd1) state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (hit) begin
            bounce_q  <= 1'b1;
            score_q   <= score_d;
            lockout_q <= 1'b1;
            hitCnt_q  <= hitCnt_d;
            speed_q   <= speed_d;
          end else if (miss) begin
            hitCnt_q <= 4'd0;
            speed_q  <= 2'd0;
            lives_q  <= lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              over_q  <= 1'b1;
              state_q <= ST_OVER;
            end else begin
              frameCnt_q <= 8'(MISS_FRAMES);
              state_q    <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (frame_tick) begin
            frameCnt_q <= frameCnt_q - 8'd1;
            if (frameCnt_q == 8'd1) begin
              serve_q    <= 1'b1;
              frameCnt_q <= 8'(SERVE_FRAMES);
              state_q    <= ST_SERVE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_serve = serve_q;
  assign bounce_x   = bounce_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign speed      = speed_q;
  assign state      = state_q;
  assign game_over  = over_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the bouncing-ball/paddle VGA game (640x480 playfield).
- Owns the serve/play/miss/game-over state machine and keeps score, lives and ball speed.
- Schedules per-frame ball movement strobes and issues serve and bounce commands to the ball datapath.
- Sits between the VGA timing block (frame_tick) and the ball/paddle position blocks.

Parameters:
LIVES, 3, lives at game start (1..3)
SERVE_FRAMES, 60, frames of delay between serve and ball release (1..255)
MISS_FRAMES, 30, frames of pause after a miss (1..255)
HIT_X, 40, ball_x at or below this value is in the paddle contact zone
MISS_X, 30, ball_x at or below this value without a hit counts as a miss (MISS_X < HIT_X)
PADDLE_H, 64, paddle height in pixels
SPEEDUP_HITS, 5, consecutive hits per speed increment (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blanking
start_btn  in  1  debounced, synchronised start button level
ball_x  in  11  current ball x
ball_y  in  11  current ball y
paddle_y  in  11  top edge of the left-side paddle
ball_step  out  1  one-cycle strobe: ball advances one pixel
ball_serve  out  1  one-cycle strobe: ball reloads its serve position
bounce_x  out  1  one-cycle strobe: force ball x direction positive
score  out  8  hit count, saturating at 255
lives  out  2  remaining lives
speed  out  2  pixels per frame minus 1
state  out  3  current FSM state encoding
game_over  out  1  high while in OVER

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk): state=IDLE; score=0; lives=LIVES; speed=0; all strobes 0; game_over=0; all internal counters 0; start-edge register 0.
- Start edge: start_btn is registered internally. A start edge is start_btn=1 with the registered copy=0. A button held through reset therefore produces no edge.
- IDLE or OVER + start edge (next cycle):
  - score=0, lives=LIVES, speed=0, hit counter=0
  - ball_serve=1 for exactly one cycle
  - frame counter=SERVE_FRAMES
  - state becomes SERVE
- SERVE:
  - Each frame_tick decrements the frame counter.
  - The tick that reaches 0 moves the state to PLAY on the next cycle.
  - No ball_step is issued in SERVE.
- PLAY, on each frame_tick:
  - Step counter is loaded with speed+1.
  - ball_step=1 on each of the next speed+1 cycles, one strobe per cycle. The first strobe comes in the cycle after frame_tick.
  - A frame_tick arriving while steps are pending reloads the step counter; pending steps are dropped.
- PLAY, collision check, evaluated in the frame_tick cycle using ball positions sampled before this frame's steps:
  - in_window = ball_y >= paddle_y AND ball_y < paddle_y+PADDLE_H. The sum is computed at 12 bits, with no wrap.
  - Hit = ball_x <= HIT_X AND in_window AND lockout=0. On a hit:
    - bounce_x=1 for one cycle (the cycle after the tick)
    - score+1, saturating at 255
    - lockout=1
    - hit counter+1; when it reaches SPEEDUP_HITS it clears to 0 and speed+1, saturating at 3
  - lockout clears on any frame_tick with ball_x > HIT_X.
  - Miss = ball_x <= MISS_X AND not Hit AND lockout=0. On a miss:
    - lives-1
    - hit counter=0, speed=0
    - step counter cleared, so no strobes follow
    - if lives was 1: state becomes OVER and lives=0
    - otherwise: state becomes MISS and frame counter=MISS_FRAMES
  - Hit and miss are mutually exclusive; hit takes priority.
- MISS:
  - No steps are issued.
  - frame_ticks count down MISS_FRAMES.
  - At 0: ball_serve=1 for one cycle, frame counter=SERVE_FRAMES, state becomes SERVE.
- OVER:
  - game_over=1.
  - score and lives are held.
  - Only a start edge leaves OVER.
- start_btn is ignored in SERVE, PLAY and MISS.
- Outputs:
  - All outputs are registered.
  - Strobes are never high for two consecutive cycles except ball_step during a multi-step frame.
  - ball_serve and bounce_x never coincide.
- Reset mid-operation: immediate return to reset values, regardless of state or pending steps.

Decomposition:
- Package game_pkg holds:
  - state encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4 (3-bit)
  - playfield constants (X_MIN=30, X_MAX=610, Y_MIN=30, Y_MAX=450)
  - width constants: coordinate width 11, score width 8
- One natural sub-module: step_sched. It holds the step counter, loads on frame_tick in PLAY and emits ball_step. It is instantiated once in game_ctrl.

Test Plan:
- Reset, then start edge: ball_serve pulses one cycle; state=SERVE; after 60 frame_ticks state=PLAY; score=0, lives=3, speed=0.
- PLAY, speed=0, ball_x=300: each frame_tick yields exactly 1 ball_step, in the next cycle. With speed forced to 2 via 10 hits: 3 consecutive ball_step cycles per frame.
- ball_x=35, paddle_y=100, ball_y=120, frame_tick: bounce_x pulse, score=1. Next tick with ball_x=34: no second hit (lockout). Tick with ball_x=41 clears lockout.
- ball_x=25, ball_y=300, paddle_y=100, frame_tick: lives 3→2, state=MISS; after 30 ticks ball_serve pulse and state=SERVE.
- Three misses: lives=0, state=OVER, game_over=1, score held. Start edge: score=0, lives=3, state=SERVE.
- Assert rst during PLAY with a step pending: all outputs at reset values the same cycle; start_btn held high through reset release produces no start.
